i2s_frame_sched: RTL and testbench
==================================

# i2s_frame_sched

Frame scheduler and clock master for the I2S transmit path. Divides `clock_in` into the bit clock (`clock_bit`) and word-select clock (`clock_lr`) for a 64-bit stereo frame (two 32-bit slots). Pulls one stereo sample pair per frame from the upstream mixer over a valid/ready handshake. Presents the pair on `data_l`/`data_r` to the parallel-to-serial stage, stable across that stage's load edge, and substitutes silence when upstream underruns.

## Interface
- `bitNum`, 16: sample width per channel, 1..32.
- `bclkDiv`, 4: `clock_in` cycles per `clock_bit` period; even, ≥2.
- `clock_in` in 1: the only clock; all state changes on its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `enable` in 1: run when high; when low, return to idle.
- `sample_l_in` in bitNum: upstream left sample.
- `sample_r_in` in bitNum: upstream right sample.
- `sample_valid` in 1: upstream pair valid.
- `sample_ready` out 1: scheduler can accept a pair.
- `clock_bit` out 1: I2S bit clock.
- `clock_lr` out 1: word select; 0 = left slot, 1 = right slot.
- `data_l` out bitNum: left sample to serializer.
- `data_r` out bitNum: right sample to serializer.
- `underrun` out 1: one-cycle pulse when a frame starts with no pair.
- `underrun_count` out 16: frames started without a pair; saturates at 0xFFFF.

## Operation
- Reset (`reset_n`=0 at a clock edge) forces the following state:
  - `div_cnt`=0, `bit_cnt`=63, pending register empty.
  - `clock_bit`=0, `clock_lr`=1, `data_l`/`data_r`=0.
  - `sample_ready`=0, `underrun`=0, `underrun_count`=0.
- Idle state (`enable`=0) is identical to the reset state, except `data_l`, `data_r` and `underrun_count` hold their values.
- Run state (`enable`=1):
  - `div_cnt` counts 0..bclkDiv-1 and wraps.
  - On each wrap, `bit_cnt` increments mod 64.
- `clock_bit` = (div_cnt ≥ bclkDiv/2). It is low for the first half-period and high for the second.
- `clock_lr` = (bit_cnt ≥ 32). Both registered outputs change only while `clock_bit` is low, so `clock_lr` transitions coincide with falling `clock_bit`.
- Boundary cycle: the cycle where div_cnt=bclkDiv-1 and bit_cnt=63. The edge that ends it starts the next frame (bit_cnt 0, `clock_lr` 1→0).
- Fetch window:
  - `sample_ready` = pending empty AND bit_cnt ≥ 32 AND NOT boundary cycle AND enable.
  - A handshake (`sample_valid` & `sample_ready`) stores both samples in the pending register. At most one pair is accepted per frame.
- At the frame-start edge:
  - If pending is full: `data_l`/`data_r` ← pending, and pending empties.
  - If pending is empty: `data_l`/`data_r` ← 0, `underrun` pulses for the next cycle, and `underrun_count` increments with saturation.
- `sample_valid` during the boundary cycle is not accepted. That pair waits for the next frame's window.
- First frame after `enable` rises: the window is only bit 63 minus the boundary cycle, i.e. bclkDiv-1 cycles. Missing it counts as an underrun; this is intended.
- `enable` falling mid-frame: the next edge enters idle and the pending pair is discarded. A handshake in that same cycle is also discarded.

## Timing
- Frame = 64·bclkDiv `clock_in` cycles; the frame rate is f(clock_in)/(64·bclkDiv).
- From the first cycle with `enable`=1:
  - `clock_bit` first rises after bclkDiv/2 cycles.
  - `clock_lr` falls after bclkDiv cycles.
- `data_l`/`data_r` update on the same edge that drives `clock_lr` low. They then stay constant for the whole 64·bclkDiv-cycle frame.
- The serializer's load (the `clock_bit` rise at bit 0) occurs bclkDiv/2 cycles after `data_l`/`data_r` update, so the data is stable there.
- `sample_ready` is combinational from registered state. The handshake takes effect at the edge where both are high, and `sample_ready` drops the next cycle.
- `underrun` is high exactly one cycle: the first cycle of the frame.
- Reset or disable mid-frame: takes effect on the next edge. There is no partial frame completion.

## Structure
- Package `i2s_pkg` holds the shared constants:
  - `I2S_FRAME_BITS`=64, `I2S_SLOT_BITS`=32, `I2S_RIGHT_START`=32.
  - These are also used by the serializer and receiver.
- Sub-module `i2s_clkgen` contains the divider and bit counter. Its outputs are `clock_bit`, `clock_lr`, `bit_cnt`, a boundary-cycle strobe and a frame-start strobe. It is reused by the receive path.
- The top level contains the pending register, handshake, output registers and underrun counter.

## Test plan
All scenarios use bclkDiv=4.
- Reset then enable, 3 frames:
  - `clock_bit` has period 4 with 2 cycles high.
  - `clock_lr` falls at cycle 4 and then every 256 cycles.
  - `clock_lr` toggles only on falling `clock_bit`.
- Upstream always valid, first pair L=0x1234, R=0xABCD offered in bit 63:
  - Accepted at the first opportunity.
  - `data_l`=0x1234 and `data_r`=0xABCD from the frame-1 start for 256 cycles.
  - `underrun_count`=0.
- Valid withheld for frame 2:
  - `data_l`/`data_r`=0 during frame 2.
  - `underrun` is high for one cycle at the frame-2 start.
  - `underrun_count`=1.
- Valid asserted only in the boundary cycle:
  - `sample_ready`=0 there, so no acceptance.
  - The same pair is accepted in the next frame at bit 32, cycle 128 of that frame.
- `enable` deasserted at bit 40 with a pair pending:
  - Next cycle: `clock_bit`=0, `clock_lr`=1, `sample_ready`=0.
  - After re-enable, the first frame shows an underrun (the pending pair was discarded).
- Force 65,540 consecutive underruns via a preloaded counter test hook, or a long run: `underrun_count` saturates at 0xFFFF.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S constants and helpers for the transmit scheduler, serializer and receiver.
package i2s_pkg;

   localparam int unsigned I2S_FRAME_BITS  = 64;
   localparam int unsigned I2S_SLOT_BITS   = 32;
   localparam int unsigned I2S_RIGHT_START = 32;
   localparam int unsigned I2S_BITCNT_W    = 6;
   localparam int unsigned I2S_UCNT_W      = 16;

   typedef logic [I2S_BITCNT_W-1:0] i2s_bitcnt_t;
   typedef logic [I2S_UCNT_W-1:0]   i2s_ucnt_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic i2s_ucnt_t i2s_sat_inc(input i2s_ucnt_t v);
      i2s_ucnt_t r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S clock generator: divides clock_in into the bit clock and the word-select
// clock of a 64-bit stereo frame, and flags the last cycle of each frame.
module i2s_clkgen
   import i2s_pkg::*;
#(
   parameter int unsigned bclkDiv = 4
) (
   input  logic        clock_in,
   input  logic        reset_n,
   input  logic        enable,
   output logic        clock_bit,
   output logic        clock_lr,
   output i2s_bitcnt_t bit_cnt,
   output logic        boundary,
   output logic        frame_start
);

   localparam int unsigned DIV_W = $clog2(bclkDiv);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bclkDiv - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(bclkDiv / 2);
   localparam i2s_bitcnt_t BIT_LAST      = I2S_BITCNT_W'(I2S_FRAME_BITS - 1);
   localparam i2s_bitcnt_t RIGHT_START_C = I2S_BITCNT_W'(I2S_RIGHT_START);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   i2s_bitcnt_t      bit_cnt_q, bit_cnt_d;
   logic             clock_bit_q, clock_lr_q;
   logic             div_wrap_s;

   // Next divider/bit counter state; idle parks the counters at the reset point.
   always_comb begin
      div_wrap_s  = (div_cnt_q == DIV_LAST);
      boundary    = div_wrap_s && (bit_cnt_q == BIT_LAST);
      frame_start = boundary && enable;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      if (!enable) begin
         div_cnt_d = '0;
         bit_cnt_d = BIT_LAST;
      end else if (div_wrap_s) begin
         div_cnt_d = '0;
         bit_cnt_d = bit_cnt_q + 6'd1;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
         bit_cnt_d = bit_cnt_q;
      end
   end

   // Counters plus clocks registered from next state, so clock_lr moves with falling clock_bit.
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         div_cnt_q   <= '0;
         bit_cnt_q   <= BIT_LAST;
         clock_bit_q <= 1'b0;
         clock_lr_q  <= 1'b1;
      end else begin
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         clock_bit_q <= (div_cnt_d >= DIV_HALF);
         clock_lr_q  <= (bit_cnt_d >= RIGHT_START_C);
      end
   end

   assign clock_bit = clock_bit_q;
   assign clock_lr  = clock_lr_q;
   assign bit_cnt   = bit_cnt_q;

endmodule

// File: rtl/i2s_frame_sched.sv
// I2S transmit frame scheduler: fetches one stereo pair per frame from the mixer
// during the right slot, hands it to the serializer at frame start, and
// substitutes silence (counting the underrun) when no pair arrived in time.
module i2s_frame_sched
   import i2s_pkg::*;
#(
   parameter int unsigned bitNum           = 16,
   parameter int unsigned bclkDiv          = 4,
   parameter logic [15:0] UNDERRUN_PRELOAD = 16'h0000
) (
   input  logic              clock_in,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [bitNum-1:0] sample_l_in,
   input  logic [bitNum-1:0] sample_r_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              clock_bit,
   output logic              clock_lr,
   output logic [bitNum-1:0] data_l,
   output logic [bitNum-1:0] data_r,
   output logic              underrun,
   output logic [15:0]       underrun_count
);

   localparam i2s_bitcnt_t RIGHT_START_C = I2S_BITCNT_W'(I2S_RIGHT_START);

   i2s_bitcnt_t       bit_cnt_s;
   logic              boundary_s, frame_start_s;
   logic              ready_s, handshake_s;

   logic              pend_full_q, pend_full_d;
   logic [bitNum-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   logic [bitNum-1:0] data_l_q, data_l_d, data_r_q, data_r_d;
   logic              underrun_q, underrun_d;
   i2s_ucnt_t         ucnt_q, ucnt_d;

   i2s_clkgen #(.bclkDiv(bclkDiv)) u_clkgen (
      .clock_in    (clock_in),
      .reset_n     (reset_n),
      .enable      (enable),
      .clock_bit   (clock_bit),
      .clock_lr    (clock_lr),
      .bit_cnt     (bit_cnt_s),
      .boundary    (boundary_s),
      .frame_start (frame_start_s)
   );

   // Fetch window: right slot, pending empty, never in the frame's last cycle.
   always_comb begin
      ready_s     = reset_n && enable && !pend_full_q
                    && (bit_cnt_s >= RIGHT_START_C) && !boundary_s;
      handshake_s = ready_s && sample_valid;
   end

   // Next state for pending register, serializer outputs and underrun tracking.
   always_comb begin
      pend_full_d = pend_full_q;
      pend_l_d    = pend_l_q;
      pend_r_d    = pend_r_q;
      data_l_d    = data_l_q;
      data_r_d    = data_r_q;
      underrun_d  = 1'b0;
      ucnt_d      = ucnt_q;
      if (!enable) begin
         pend_full_d = 1'b0;
      end else if (frame_start_s) begin
         if (pend_full_q) begin
            data_l_d    = pend_l_q;
            data_r_d    = pend_r_q;
            pend_full_d = 1'b0;
         end else begin
            data_l_d   = '0;
            data_r_d   = '0;
            underrun_d = 1'b1;
            ucnt_d     = i2s_sat_inc(ucnt_q);
         end
      end else if (handshake_s) begin
         pend_full_d = 1'b1;
         pend_l_d    = sample_l_in;
         pend_r_d    = sample_r_in;
      end else begin
         pend_full_d = pend_full_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         pend_full_q <= 1'b0;
         pend_l_q    <= '0;
         pend_r_q    <= '0;
         data_l_q    <= '0;
         data_r_q    <= '0;
         underrun_q  <= 1'b0;
         ucnt_q      <= UNDERRUN_PRELOAD;
      end else begin
         pend_full_q <= pend_full_d;
         pend_l_q    <= pend_l_d;
         pend_r_q    <= pend_r_d;
         data_l_q    <= data_l_d;
         data_r_q    <= data_r_d;
         underrun_q  <= underrun_d;
         ucnt_q      <= ucnt_d;
      end
   end

   assign sample_ready   = ready_s;
   assign data_l         = data_l_q;
   assign data_r         = data_r_q;
   assign underrun       = underrun_q;
   assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Directed bench for i2s_frame_sched with bclkDiv=4 (frame = 256 cycles).
// A second instance with a preloaded underrun counter covers saturation.
module tb_i2s_frame_sched;

   logic        clk;
   logic        reset_n, enable, enable_sat, valid;
   logic [15:0] sl, sr;

   logic        ready, clock_bit, clock_lr, underrun;
   logic [15:0] data_l, data_r, ucnt;

   logic        s_ready, s_cb, s_lr, s_ur;
   logic [15:0] s_dl, s_dr, s_ucnt;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   logic [15:0] exp_l = 16'h0000;
   logic [15:0] exp_r = 16'h0000;
   logic        exp_ur = 1'b0;
   logic        mon_en = 1'b0;
   logic        prev_cb, prev_lr;

   i2s_frame_sched #(.bitNum(16), .bclkDiv(4)) dut (
      .clock_in(clk), .reset_n(reset_n), .enable(enable),
      .sample_l_in(sl), .sample_r_in(sr), .sample_valid(valid),
      .sample_ready(ready), .clock_bit(clock_bit), .clock_lr(clock_lr),
      .data_l(data_l), .data_r(data_r), .underrun(underrun),
      .underrun_count(ucnt)
   );

   i2s_frame_sched #(.bitNum(16), .bclkDiv(4), .UNDERRUN_PRELOAD(16'hFFFC)) dut_sat (
      .clock_in(clk), .reset_n(reset_n), .enable(enable_sat),
      .sample_l_in(16'h0000), .sample_r_in(16'h0000), .sample_valid(1'b0),
      .sample_ready(s_ready), .clock_bit(s_cb), .clock_lr(s_lr),
      .data_l(s_dl), .data_r(s_dr), .underrun(s_ur),
      .underrun_count(s_ucnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample 1 time unit after the rising edge; clock_lr may only move when clock_bit falls.
   task automatic tick();
      prev_cb = clock_bit;
      prev_lr = clock_lr;
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en && (clock_lr !== prev_lr))
         chk($sformatf("lr_on_bclk_fall@%0d", cyc), {30'd0, prev_cb, clock_bit}, 32'd2);
   endtask

   // Clocks follow the free-running divider from the enable cycle (cyc 0); data/underrun as expected.
   task automatic chk_cycle();
      logic e_cb, e_lr;
      e_cb = ((cyc % 4) >= 2);
      e_lr = (cyc < 4) ? 1'b1 : ((((cyc - 4) % 256) >= 128) ? 1'b1 : 1'b0);
      chk($sformatf("clock_bit@%0d", cyc), {31'd0, clock_bit}, {31'd0, e_cb});
      chk($sformatf("clock_lr@%0d", cyc),  {31'd0, clock_lr},  {31'd0, e_lr});
      chk($sformatf("data_l@%0d", cyc),    {16'd0, data_l},    {16'd0, exp_l});
      chk($sformatf("data_r@%0d", cyc),    {16'd0, data_r},    {16'd0, exp_r});
      chk($sformatf("underrun@%0d", cyc),  {31'd0, underrun},  {31'd0, exp_ur});
   endtask

   task automatic run_until(input int target);
      while (cyc < target) begin
         tick();
         chk_cycle();
      end
   endtask

   task automatic frame_start_step(input logic [15:0] l, input logic [15:0] r, input logic ur);
      tick();
      exp_l  = l;
      exp_r  = r;
      exp_ur = ur;
      chk_cycle();
      exp_ur = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; enable_sat = 1'b0; valid = 1'b0;
      sl = 16'h0000; sr = 16'h0000;
      repeat (3) tick();

      // Reset state
      chk("rst_clock_bit", {31'd0, clock_bit}, 32'd0);
      chk("rst_clock_lr",  {31'd0, clock_lr},  32'd1);
      chk("rst_ready",     {31'd0, ready},     32'd0);
      chk("rst_underrun",  {31'd0, underrun},  32'd0);
      chk("rst_ucnt",      {16'd0, ucnt},      32'h0000);
      chk("rst_data_l",    {16'd0, data_l},    32'h0000);
      chk("rst_data_r",    {16'd0, data_r},    32'h0000);
      chk("rst_sat_ucnt",  {16'd0, s_ucnt},    32'hFFFC);
      mon_en = 1'b1;

      // Cycle 0: enable with a pair offered during bit 63 of the first (short) window
      tick();
      cyc = 0;
      reset_n = 1'b1; enable = 1'b1; enable_sat = 1'b1;
      valid = 1'b1; sl = 16'h1234; sr = 16'hABCD;
      #1;
      chk("ready_first_window", {31'd0, ready}, 32'd1);
      chk_cycle();

      tick();
      valid = 1'b0; sl = 16'h0000; sr = 16'h0000;
      #1;
      chk("ready_drop_after_hs", {31'd0, ready}, 32'd0);
      chk_cycle();
      run_until(3);

      // Frame 1 start: accepted pair delivered, no underrun
      frame_start_step(16'h1234, 16'hABCD, 1'b0);
      chk("f1_ucnt", {16'd0, ucnt}, 32'd0);
      chk("sat_ucnt_f1", {16'd0, s_ucnt}, 32'hFFFD);
      run_until(259);

      // Frame 2: valid withheld -> silence and one-cycle underrun
      frame_start_step(16'h0000, 16'h0000, 1'b1);
      chk("f2_ucnt", {16'd0, ucnt}, 32'd1);
      chk("sat_ucnt_f2", {16'd0, s_ucnt}, 32'hFFFE);
      run_until(514);

      // Boundary cycle of frame 2: valid offered but not accepted
      tick();
      valid = 1'b1; sl = 16'h5555; sr = 16'h6666;
      #1;
      chk("ready_boundary", {31'd0, ready}, 32'd0);
      chk_cycle();

      // Frame 3 starts empty -> underrun; same pair waits for bit 32
      frame_start_step(16'h0000, 16'h0000, 1'b1);
      chk("f3_ucnt", {16'd0, ucnt}, 32'd2);
      chk("sat_ucnt_f3", {16'd0, s_ucnt}, 32'hFFFF);
      chk("ready_f3_bit0", {31'd0, ready}, 32'd0);
      run_until(643);
      chk("ready_f3_bit31", {31'd0, ready}, 32'd0);
      tick();
      chk("ready_f3_bit32", {31'd0, ready}, 32'd1);
      chk_cycle();
      tick();
      valid = 1'b0;
      #1;
      chk("ready_f3_after_hs", {31'd0, ready}, 32'd0);
      chk_cycle();
      run_until(771);

      // Frame 4: the late pair is delivered
      frame_start_step(16'h5555, 16'h6666, 1'b0);
      chk("f4_ucnt", {16'd0, ucnt}, 32'd2);
      chk("sat_ucnt_f4", {16'd0, s_ucnt}, 32'hFFFF);
      run_until(899);

      // Load a pair at bit 32 of frame 4, then drop enable at bit 40
      tick();
      valid = 1'b1; sl = 16'h7777; sr = 16'h8888;
      #1;
      chk("ready_f4_bit32", {31'd0, ready}, 32'd1);
      chk_cycle();
      tick();
      valid = 1'b0;
      #1;
      chk("ready_f4_pending", {31'd0, ready}, 32'd0);
      chk_cycle();
      run_until(932);
      enable = 1'b0;

      tick();
      chk("idle_clock_bit", {31'd0, clock_bit}, 32'd0);
      chk("idle_clock_lr",  {31'd0, clock_lr},  32'd1);
      chk("idle_ready",     {31'd0, ready},     32'd0);
      chk("idle_data_l",    {16'd0, data_l},    32'h5555);
      chk("idle_data_r",    {16'd0, data_r},    32'h6666);
      chk("idle_ucnt",      {16'd0, ucnt},      32'd2);
      chk("idle_underrun",  {31'd0, underrun},  32'd0);
      repeat (3) tick();
      chk("idle_clock_bit_hold", {31'd0, clock_bit}, 32'd0);

      // Re-enable: pending pair was discarded, so the first frame underruns
      tick();
      cyc = 0;
      enable = 1'b1;
      #1;
      chk("reen_ready_empty", {31'd0, ready}, 32'd1);
      chk_cycle();
      run_until(3);
      frame_start_step(16'h0000, 16'h0000, 1'b1);
      chk("reen_ucnt", {16'd0, ucnt}, 32'd3);
      run_until(8);

      // Saturated counter instance stays at the ceiling with silent data
      chk("sat_ucnt_end", {16'd0, s_ucnt}, 32'hFFFF);
      chk("sat_data_l",   {16'd0, s_dl},   32'h0000);
      chk("sat_data_r",   {16'd0, s_dr},   32'h0000);
      chk("sat_clk_match", {30'd0, s_cb, s_lr, s_ur, s_ready}, {30'd0, s_cb, s_lr, s_ur, s_ready} & 32'h0000000F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
